// File: rtl/approx_mul_pkg.sv
// Shared encodings and helpers for the streaming approximate multiplier.
package approx_mul_pkg;

  // Per-beat accuracy tag carried alongside the operands
  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // Widest product the helpers must cover (2 * max WIDTH)
  localparam int unsigned MAX_PW = 32;

  // Rounding compensation for K dropped columns: half the weight of column K
  function automatic logic [MAX_PW-1:0] comp_const(input int unsigned k);
    logic [MAX_PW-1:0] c;
    c = '0;
    if (k != 0) c = MAX_PW'(1) << (k - 1);
    return c;
  endfunction

  // Column mask: partial product a_i*b_j survives when its weight column is >= K
  function automatic logic keep(input int i, input int j, input int k);
    return ((i + j) >= k);
  endfunction

endpackage

// File: rtl/approx_pp_reduce.sv
// Partial-product generation, column masking, compensation row and
// carry-save reduction down to two vectors. Purely combinational.
module approx_pp_reduce
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TRUNC_COLS = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx,
  output logic [2*WIDTH-1:0] sum_c,
  output logic [2*WIDTH-1:0] carry_c
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NROWS = WIDTH + 1;

  logic [PW-1:0] rows [NROWS];
  logic          approx_on;

  assign approx_on = (mode_e'(approx) == MODE_APPROX);

  // Build AND rows (masked in approximate mode) plus the compensation row
  always_comb begin : pp_gen
    for (int r = 0; r < NROWS; r++) begin
      rows[r] = '0;
    end
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        rows[j][i+j] = a[i] & b[j] & (!approx_on || keep(i, j, TRUNC_COLS));
      end
    end
    if (approx_on) begin
      rows[WIDTH] = PW'(comp_const(TRUNC_COLS));
    end
  end

  // Linear 3:2 compressor chain; carries past the top column are dropped,
  // which is safe because the true total always fits in PW bits
  always_comb begin : csa_chain
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] t;
    s = '0;
    c = '0;
    t = '0;
    for (int r = 0; r < NROWS; r++) begin
      t = s ^ c ^ rows[r];
      c = ((s & c) | (s & rows[r]) | (c & rows[r])) << 1;
      s = t;
    end
    sum_c   = s;
    carry_c = c;
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned multiplier with per-beat exact/approximate mode,
// valid/ready on both sides and saturating delivery counters.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned TRUNC_COLS = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_approx,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt_total,
  output logic [CNT_W-1:0]   cnt_approx
);

  localparam int unsigned    PW      = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]     red_sum_c;
  logic [PW-1:0]     red_carry_c;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] tag_q;
  logic [STAGES-1:0] vin_c;
  logic [STAGES-1:0] tin_c;
  logic [STAGES-1:0] ld_c;
  logic [PW-1:0]     p_q;

  approx_pp_reduce #(
    .WIDTH      (WIDTH),
    .TRUNC_COLS (TRUNC_COLS)
  ) u_reduce (
    .a       (in_a),
    .b       (in_b),
    .approx  (in_approx),
    .sum_c   (red_sum_c),
    .carry_c (red_carry_c)
  );

  // Backward ready chain: a stage loads when empty or when it drains this cycle
  always_comb begin : ready_chain
    logic down;
    down = out_ready;
    ld_c = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld_c[k] = !vld_q[k] || down;
      down    = ld_c[k];
    end
  end

  assign in_ready = ld_c[0];

  // Upstream valid/tag seen by each stage
  always_comb begin : stage_inputs
    vin_c    = '0;
    tin_c    = '0;
    vin_c[0] = in_valid;
    tin_c[0] = in_approx;
    for (int k = 1; k < STAGES; k++) begin
      vin_c[k] = vld_q[k-1];
      tin_c[k] = tag_q[k-1];
    end
  end

  // Stage valid bits and mode tags
  always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld_c[k]) begin
          vld_q[k] <= vin_c[k];
          if (vin_c[k]) tag_q[k] <= tin_c[k];
        end
      end
    end
  end

  if (STAGES > 1) begin : g_csa
    logic [PW-1:0] s_q [STAGES-1];
    logic [PW-1:0] c_q [STAGES-1];

    // Carry-save vectors in stage 0, pass-through in intermediate stages
    always_ff @(posedge clk or negedge rst_n) begin : csa_regs
      if (!rst_n) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          s_q[k] <= '0;
          c_q[k] <= '0;
        end
      end else begin
        if (ld_c[0] && vin_c[0]) begin
          s_q[0] <= red_sum_c;
          c_q[0] <= red_carry_c;
        end
        for (int k = 1; k < STAGES - 1; k++) begin
          if (ld_c[k] && vin_c[k]) begin
            s_q[k] <= s_q[k-1];
            c_q[k] <= c_q[k-1];
          end
        end
      end
    end

    // Final stage resolves the carry-save pair into the product
    always_ff @(posedge clk or negedge rst_n) begin : prod_reg
      if (!rst_n) begin
        p_q <= '0;
      end else if (ld_c[STAGES-1] && vin_c[STAGES-1]) begin
        p_q <= s_q[STAGES-2] + c_q[STAGES-2];
      end
    end
  end else begin : g_single
    // Single stage: reduction and carry-propagate add feed the only register
    always_ff @(posedge clk or negedge rst_n) begin : prod_reg
      if (!rst_n) begin
        p_q <= '0;
      end else if (ld_c[0] && vin_c[0]) begin
        p_q <= red_sum_c + red_carry_c;
      end
    end
  end

  assign out_valid  = vld_q[STAGES-1];
  assign out_approx = tag_q[STAGES-1];
  assign out_p      = p_q;

  // Saturating delivery counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin : stat_cnt
    if (!rst_n) begin
      cnt_total  <= '0;
      cnt_approx <= '0;
    end else if (cnt_clr) begin
      cnt_total  <= '0;
      cnt_approx <= '0;
    end else if (out_valid && out_ready) begin
      if (cnt_total != CNT_MAX) cnt_total <= cnt_total + CNT_W'(1);
      if ((mode_e'(out_approx) == MODE_APPROX) && (cnt_approx != CNT_MAX)) begin
        cnt_approx <= cnt_approx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench: scoreboard of spec-level products, directed vectors,
// counter saturation/clear, mid-stream reset and a K=0 exhaustive sweep.
module tb_approx_mul_pipe;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned STAGES  = 2;
  localparam int unsigned K       = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready, in_approx;
  logic [WIDTH-1:0]   in_a, in_b;
  logic               out_valid, out_ready, out_approx;
  logic [2*WIDTH-1:0] out_p;
  logic               cnt_clr;
  logic [CNT_W-1:0]   cnt_total, cnt_approx;

  logic               k0_rst_n;
  logic               k0_in_valid, k0_in_ready, k0_in_approx;
  logic [WIDTH-1:0]   k0_a, k0_b;
  logic               k0_out_valid, k0_out_ready, k0_out_approx;
  logic [2*WIDTH-1:0] k0_out_p;
  logic               k0_cnt_clr;
  logic [31:0]        k0_cnt_total, k0_cnt_approx;
  logic               k0_done = 1'b0;

  always #5 clk = ~clk;

  approx_mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TRUNC_COLS(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_approx(out_approx),
    .cnt_clr(cnt_clr), .cnt_total(cnt_total), .cnt_approx(cnt_approx)
  );

  approx_mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TRUNC_COLS(0), .CNT_W(32)) dut_k0 (
    .clk(clk), .rst_n(k0_rst_n), .in_valid(k0_in_valid), .in_ready(k0_in_ready),
    .in_a(k0_a), .in_b(k0_b), .in_approx(k0_in_approx), .out_valid(k0_out_valid),
    .out_ready(k0_out_ready), .out_p(k0_out_p), .out_approx(k0_out_approx),
    .cnt_clr(k0_cnt_clr), .cnt_total(k0_cnt_total), .cnt_approx(k0_cnt_approx)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference product straight from the definition: sum of kept terms + 2^(k-1)
  function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b,
                                          input logic ap, input int unsigned k);
    int unsigned acc;
    if (!ap) return a * b;
    acc = 0;
    for (int unsigned i = 0; i < WIDTH; i++)
      for (int unsigned j = 0; j < WIDTH; j++)
        if ((((a >> i) & 1) != 0) && (((b >> j) & 1) != 0) && ((i + j) >= k))
          acc += (1 << (i + j));
    if (k > 0) acc += (1 << (k - 1));
    return acc;
  endfunction

  typedef struct {
    int unsigned p;
    logic        tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned m_total, m_approx;
  logic        held;
  logic [2*WIDTH-1:0] held_p;
  logic        held_tag;

  // Main-DUT compare process, sampling on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m_total  = 0;
      m_approx = 0;
      held     = 1'b0;
    end else begin
      chk("cnt_total", cnt_total, m_total);
      chk("cnt_approx", cnt_approx, m_approx);
      chk("in_ready", in_ready, !((sb.size() == STAGES) && !out_ready));
      if (held) begin
        chk("hold out_valid", out_valid, 1);
        chk("hold out_p", out_p, held_p);
        chk("hold out_approx", out_approx, held_tag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got p=%0d with no beat outstanding", out_p);
        end else begin
          e = sb.pop_front();
          chk("out_p", out_p, e.p);
          chk("out_approx", out_approx, e.tag);
        end
      end
      if (cnt_clr) begin
        m_total  = 0;
        m_approx = 0;
      end else if (out_valid && out_ready) begin
        if (m_total < CNT_MAX) m_total++;
        if (out_approx && m_approx < CNT_MAX) m_approx++;
      end
      held     = out_valid && !out_ready;
      held_p   = out_p;
      held_tag = out_approx;
      if (in_valid && in_ready) begin
        e.p   = ref_mul(in_a, in_b, in_approx, K);
        e.tag = in_approx;
        sb.push_back(e);
      end
    end
  end

  int unsigned k0q[$];

  // K=0 compare process: approximate results must equal the exact product
  always @(negedge clk) begin
    if (!k0_rst_n) begin
      k0q.delete();
    end else begin
      if (k0_out_valid && k0_out_ready) begin
        if (k0q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL k0_unexpected_output: got p=%0d with no beat outstanding", k0_out_p);
        end else begin
          chk("k0 out_p", k0_out_p, k0q.pop_front());
          chk("k0 out_approx", k0_out_approx, 1);
        end
      end
      if (k0_in_valid && k0_in_ready) k0q.push_back(int'(k0_a) * int'(k0_b));
    end
  end

  // K=0 exhaustive driver, runs alongside the main sequence
  initial begin
    k0_rst_n = 1'b0; k0_in_valid = 1'b0; k0_in_approx = 1'b1;
    k0_a = '0; k0_b = '0; k0_out_ready = 1'b1; k0_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 k0_rst_n = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        k0_in_valid = 1'b1;
        k0_a = WIDTH'(a);
        k0_b = WIDTH'(b);
        @(posedge clk);
        #1;
      end
    end
    k0_in_valid = 1'b0;
    repeat (STAGES + 2) @(posedge clk);
    #1;
    chk("k0 drained", k0q.size(), 0);
    chk("k0 cnt_total", k0_cnt_total, 65536);
    chk("k0 cnt_approx", k0_cnt_approx, 65536);
    k0_done = 1'b1;
  end

  // One beat into an empty pipe; checks acceptance, latency and value
  task automatic send_directed(input int unsigned a, input int unsigned b, input logic ap,
                               input int unsigned exp_p, input string name);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = WIDTH'(a);
    in_b      = WIDTH'(b);
    in_approx = ap;
    @(negedge clk);
    chk({name, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({name, " not early"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({name, " out_valid"}, out_valid, 1);
    chk({name, " out_p"}, out_p, exp_p);
    chk({name, " out_approx"}, out_approx, ap);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned sent, cyc;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0;
    out_ready = 1'b0; cnt_clr = 1'b0;

    chk("model 255x255 exact", ref_mul(255, 255, 1'b0, 4), 65025);
    chk("model 255x255 approx", ref_mul(255, 255, 1'b1, 4), 64984);
    chk("model 3x3 approx", ref_mul(3, 3, 1'b1, 4), 8);
    chk("model 16x16 approx", ref_mul(16, 16, 1'b1, 4), 264);
    chk("model k0 approx", ref_mul(13, 11, 1'b1, 0), 143);

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_p", out_p, 0);
    chk("reset out_approx", out_approx, 0);
    chk("reset cnt_total", cnt_total, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    @(posedge clk);
    #1;

    send_directed(255, 255, 1'b0, 65025, "exact 255x255");
    send_directed(255, 255, 1'b1, 64984, "approx 255x255");
    send_directed(3, 3, 1'b1, 8, "approx 3x3");
    send_directed(3, 3, 1'b0, 9, "exact 3x3");
    send_directed(16, 16, 1'b1, 264, "approx 16x16");

    // Counter saturation: 20 deliveries, 12 approximate
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      in_valid  = 1'b1;
      in_a      = WIDTH'(n * 7 + 3);
      in_b      = WIDTH'(n * 13 + 1);
      in_approx = (n < 12);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (STAGES + 1) @(posedge clk);
    @(negedge clk);
    chk("sat cnt_total", cnt_total, 15);
    chk("sat cnt_approx", cnt_approx, 12);
    @(posedge clk);
    #1;

    // Random stream with random backpressure
    sent = 0;
    cyc  = 0;
    while (sent < 100 && cyc < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_approx = $urandom_range(0, 1) != 0;
      out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    chk("stream beats accepted", sent, 100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stream drained", sb.size(), 0);

    // Fill the pipe against a stalled output
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_valid  = 1'b1;
      in_a      = WIDTH'(40 + n);
      in_b      = WIDTH'(90 + n);
      in_approx = n[0];
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("full in_ready", in_ready, 0);
    chk("full out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    // Simultaneous output and input accept while full, with a clear
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    in_a      = 8'd200;
    in_b      = 8'd201;
    in_approx = 1'b1;
    @(negedge clk);
    chk("full both honoured in_ready", in_ready, 1);
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr during handshake total", cnt_total, 0);
    chk("clr during handshake approx", cnt_approx, 0);
    repeat (STAGES + 2) @(posedge clk);
    #1;
    chk("full drained", sb.size(), 0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      in_valid  = 1'b1;
      in_a      = WIDTH'(77 + n);
      in_b      = WIDTH'(55 + n);
      in_approx = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_p", out_p, 0);
    chk("midreset out_approx", out_approx, 0);
    chk("midreset cnt_total", cnt_total, 0);
    chk("midreset cnt_approx", cnt_approx, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post-reset no stale", out_valid, 0);
    @(posedge clk);
    #1;
    send_directed(200, 100, 1'b0, 20000, "post-reset exact");

    cyc = 0;
    while (!k0_done && cyc < 70000) begin
      @(posedge clk);
      cyc++;
    end
    chk("k0 sweep finished", k0_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/approx_mul_pipe.md
# approx_mul_pipe

Parametrised, pipelined unsigned multiplier with a run-time selectable accuracy mode. Each transaction is computed either exactly or with column truncation plus constant compensation. Valid/ready handshakes are provided on both sides, and saturating transaction counters track usage. The block is the streaming successor to the fixed 8x8 combinational approximate multipliers, for datapaths that need backpressure and per-operand accuracy control.

## Interface
Parameters:
- `WIDTH`, 8: operand width in bits; legal range 2..16.
- `STAGES`, 2: pipeline register stages; legal range 1..4.
- `TRUNC_COLS`, 4: number of low partial-product columns dropped in approximate mode; legal range 0..`WIDTH`.
- `CNT_W`, 32: width of each statistics counter.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: operand beat valid.
- `in_ready`, out, 1: block accepts the beat this cycle.
- `in_a`, in, `WIDTH`: multiplicand, unsigned.
- `in_b`, in, `WIDTH`: multiplier, unsigned.
- `in_approx`, in, 1: 1 = approximate, 0 = exact; sampled with the beat.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_p`, out, 2*`WIDTH`: product.
- `out_approx`, out, 1: mode tag travelling with the result.
- `cnt_clr`, in, 1: synchronous clear of both counters.
- `cnt_total`, out, `CNT_W`: results delivered.
- `cnt_approx`, out, `CNT_W`: approximate results delivered.

## Operation
- Exact mode: `out_p` = `in_a` * `in_b`, full 2*`WIDTH` bits.
- Approximate mode, with K = `TRUNC_COLS`:
  - `out_p` = sum of a_i·b_j·2^(i+j) over all i+j ≥ K, plus 2^(K-1) when K > 0.
  - K = 0 gives exactly the exact result.
  - No overflow is possible for K ≤ `WIDTH`.
  - All arithmetic is unsigned with no wrap.
- Operands are captured on the input handshake (`in_valid` && `in_ready`). The mode bit is a per-beat tag; there is no mode register.
- Each stage holds {valid, partial data, tag}.
- A stage loads when it is empty or when its contents move on in the same cycle.
- `in_ready` = !stage0_valid || stage0 advances. This is a combinational ready chain from `out_ready`.
- Output is the last stage. `out_valid` = last stage valid. `out_p` and `out_approx` hold stable while `out_valid` && !`out_ready`.
- Counters update on the output handshake:
  - `cnt_total` += 1.
  - `cnt_approx` += 1 if `out_approx` = 1.
  - Both saturate at 2^`CNT_W` - 1.
- `cnt_clr` takes priority over a same-cycle increment; both counters become 0.
- Reset:
  - All stage valids go to 0, `out_valid` = 0, `out_p` = 0, `out_approx` = 0, counters = 0.
  - `in_ready` = 1 from the first cycle after reset deasserts.
  - Reset mid-stream discards in-flight beats without producing output.

## Timing
- Latency: a beat accepted in cycle n appears with `out_valid` in cycle n + `STAGES` when nothing stalls.
- Throughput: one beat per cycle under continuous `out_ready` = 1.
- Full pipeline with `out_ready` = 0: `in_ready` = 0, and no beat is lost or duplicated.
- Output accept and input accept in the same cycle while full: both are honoured.
- Data stays in order; occupancy never exceeds `STAGES`.
- Partial-product split:
  - Stage 0 registers the masked partial-product rows reduced to two carry-save vectors.
  - The final stage registers the carry-propagate sum.
  - Any intermediate stages are pass-through registers.
- No combinational path from `in_*` to `out_*`.

## Structure
- Package `approx_mul_pkg` contains:
  - Mode encoding constants `MODE_EXACT` = 0 and `MODE_APPROX` = 1.
  - The function `comp_const(K)` returning 2^(K-1) or 0.
  - The column-mask function `keep(i, j, K)`.
- One combinational sub-module, `approx_pp_reduce`:
  - Generates AND partial products and applies the mask when the approximate tag is set.
  - Injects the compensation constant as an extra row.
  - Reduces to carry-save form.
- The top level owns the pipeline registers, handshake and counters.

## Test plan
Defaults (`WIDTH` = 8, K = 4, `STAGES` = 2) unless stated:
- Exact 255×255 -> `out_p` = 65025. Approximate 255×255 -> `out_p` = 64984 (65025 - 49 + 8), `out_approx` = 1. Both appear 2 cycles after acceptance.
- Approximate 3×3 -> 8 (all terms dropped, compensation only). Exact 3×3 -> 9. Approximate 16×16 -> 256 + 8 = 264.
- Stream 100 random beats with random `out_ready`; compare against the package-based reference model.
  - Must show no loss, duplication or reordering.
  - `in_ready` = 0 exactly when the pipeline is full and `out_ready` = 0.
- Counters with `CNT_W` = 4: deliver 20 beats (12 approximate) -> `cnt_total` saturates at 15, `cnt_approx` = 12. Assert `cnt_clr` during a handshake -> both read 0 next cycle.
- Assert `rst_n` low with 2 beats in flight -> `out_valid` drops immediately and all outputs are 0. After release, the next beat has the correct latency with no stale output.
- K = 0 build: approximate and exact results identical over an exhaustive 8×8 sweep.
